// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: converts a valid/ready command stream
// into single read/write bus cycles and returns one response per command,
// carrying either the read data or a timeout error.
module wb_cmd_master #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic            w_to;

  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [31:0]     r_adr;
  logic [31:0]     r_wdat;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [31:0]     r_rsp_dat;

  // Last waiting cycle: without an ack on this edge the cycle is abandoned.
  assign w_to = (r_cnt == TO_W'(TIMEOUT - 1));

  // Accept only from IDLE; decoded straight from the state register.
  assign cmd_ready_o = (r_state == S_IDLE);

  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_stb;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_wdat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_dat_o   = r_rsp_dat;

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state decode; an ack on the timeout edge takes the same path as a normal ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid_i)           w_state_nxt = S_BUS;
      S_BUS:   if (wbm_ack_i || w_to)     w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i)           w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs, timeout counter and response registers; ack is ignored outside BUS.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_we   <= cmd_we_i;
            r_adr  <= cmd_adr_i;
            r_wdat <= cmd_dat_i;
            r_sel  <= cmd_sel_i;
            r_cyc  <= 1'b1;
            r_stb  <= 1'b1;
            r_cnt  <= '0;
          end
        end
        S_BUS: begin
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= r_we ? 32'd0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else if (w_to) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic-cycle initiator (master) for the user area.
- Turns a simple valid/ready command stream into single Wishbone read/write cycles toward a slave with the standard wbs_* port set.
- Returns one response per command, with read data or a timeout error.
- Used for bring-up: it lets a logic-analyzer-driven or GPIO-driven controller exercise Wishbone slaves in the user project.

Parameters:
- TIMEOUT, 255: cycles the master waits for wbm_ack_i before abandoning the cycle. Legal range 1..(2^TO_W)-1.
- TO_W, 8: width of the timeout counter.

Ports:
- wb_clk_i  input  1  single clock; all logic is rising-edge.
- wb_rst_i  input  1  asynchronous reset, active-low (0 = reset).
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  master can accept a command.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_adr_i  input  32  byte address.
- cmd_dat_i  input  32  write data.
- cmd_sel_i  input  4  byte selects.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_dat_o  output  32  read data; 0 for writes and errors.
- rsp_err_o  output  1  1 = cycle timed out.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte selects.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone acknowledge.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - state=IDLE.
  - All wbm_* outputs are 0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, timeout counter=0.
  - cmd_ready_o follows state, so it is 1 while in reset.
- States: IDLE, BUS, RESP. cmd_ready_o = (state==IDLE), decoded combinationally from the state register.
- IDLE:
  - On an edge with cmd_valid_i=1, register we/adr/dat/sel onto the wbm_* outputs.
  - Set wbm_cyc_o=wbm_stb_o=1, clear the counter, go to BUS.
  - The master makes no changes to cmd_* values; all cmd_* inputs are sampled at the accept edge only.
- BUS:
  - cyc, stb and all wbm_* outputs are held stable.
  - On an edge with wbm_ack_i=1:
    - cyc=stb=0; wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their values.
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write.
    - rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - Otherwise the counter increments. On the edge where the counter equals TIMEOUT-1 and ack=0: cyc=stb=0, rsp_err_o=1, rsp_dat_o=0, rsp_valid_o=1, go to RESP.
  - With no ack, the timeout response is therefore valid after exactly TIMEOUT BUS cycles.
  - Ack on the timeout edge: ack wins, error=0.
- RESP:
  - rsp_* outputs are held stable until an edge with rsp_ready_i=1.
  - On that edge: rsp_valid_o=0, rsp_err_o=0, go to IDLE.
  - rsp_dat_o keeps its last value until the next response is loaded.
  - The earliest next command accept is the edge after the response handshake, because cmd_ready_o rises in IDLE.
- Latency with a zero-wait slave (combinational ack on stb):
  - Accept at edge N; stb high during cycle N→N+1.
  - Ack sampled at edge N+1; rsp_valid_o high from N+1.
  - Throughput with rsp_ready_i held 1: one command per 3 cycles.
- wbm_ack_i in IDLE or RESP is ignored: no state change and no output change.
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronous). The pending command and response are discarded with no response.
- No bursts, no retry, no err/rty inputs. Address bits are passed unmodified; the master does no alignment.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks 1 cycle after stb -> bus shows those values with cyc=stb=we=1 for 2 cycles; rsp_valid=1, err=0, rsp_dat=0.
- Read with 3 wait states: slave returns 0x1234_5678 -> stb high exactly 4 cycles, rsp_dat=0x1234_5678, err=0; cmd_ready=0 from accept until the rsp handshake.
- Timeout, TIMEOUT=4, no ack -> cyc/stb high exactly 4 cycles then 0; rsp_valid=1, err=1, rsp_dat=0. Also: ack arriving on the 4th cycle -> err=0 with the read data.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable and cmd_ready=0 throughout; a new cmd_valid is not accepted until the cycle after the handshake.
- Async reset low mid-BUS (not aligned to a clock edge) -> cyc/stb/rsp_valid go 0 immediately; after release, cmd_ready=1 and the next read completes normally.
- Spurious wbm_ack_i pulses in IDLE and RESP -> no state, response or bus change.
